// File: rtl/idma_backend_req_arbiter.sv
// Round-robin arbiter sharing one iDMA backend between NumReq frontends.
// An in-order FIFO of granted requester indices routes each backend response back to its issuer.
module idma_backend_req_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned RspWidth       = 64,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     req_valid_i,
    output logic [NumReq-1:0]                     req_ready_o,
    input  logic [NumReq*ReqWidth-1:0]            req_i,
    output logic [NumReq-1:0]                     rsp_valid_o,
    input  logic [NumReq-1:0]                     rsp_ready_i,
    output logic [RspWidth-1:0]                   rsp_o,
    output logic [ReqWidth-1:0]                   be_req_o,
    output logic                                  be_req_valid_o,
    input  logic                                  be_req_ready_i,
    input  logic [RspWidth-1:0]                   be_rsp_i,
    input  logic                                  be_rsp_valid_i,
    output logic                                  be_rsp_ready_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  idle_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] head;
    logic            found;
    logic            full, empty, req_hs, rsp_hs;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CntW'(MaxOutstanding));
    assign empty = (count_q == '0);

    // Locked grant wins outright; otherwise scan from rr_ptr_q with wrap.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        if (lock_q) begin
            winner = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (!found && req_valid_i[IdxW'((int'(rr_ptr_q) + i) % NumReq)]) begin
                    winner = IdxW'((int'(rr_ptr_q) + i) % NumReq);
                    found  = 1'b1;
                end
            end
        end
    end

    assign be_req_valid_o = (|req_valid_i) & ~full;
    assign be_req_o       = req_i[winner*ReqWidth +: ReqWidth];
    assign req_ready_o    = (be_req_valid_o & be_req_ready_i) ? (NumReq'(1) << winner) : '0;
    assign req_hs         = be_req_valid_o & be_req_ready_i;

    assign head           = fifo_q[rd_ptr_q];
    assign rsp_valid_o    = (~empty & be_rsp_valid_i) ? (NumReq'(1) << head) : '0;
    assign be_rsp_ready_o = ~empty & rsp_ready_i[head];
    assign rsp_o          = be_rsp_i;
    assign rsp_hs         = be_rsp_valid_i & be_rsp_ready_o;

    assign outstanding_o  = count_q;
    assign idle_o         = empty & ~(|req_valid_i);

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (req_hs) begin
            lock_d   = 1'b0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            rr_ptr_d = (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
        end else if (be_req_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end
        if (rsp_hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (req_hs && !rsp_hs) begin
            count_d = count_q + 1'b1;
        end else if (!req_hs && rsp_hs) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Index storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (req_hs) begin
            fifo_q[wr_ptr_q] <= winner;
        end
    end

endmodule

// File: tb/tb_idma_backend_req_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference.
module tb_idma_backend_req_arbiter;

    localparam int NumReq   = 4;
    localparam int ReqWidth = 128;
    localparam int RspWidth = 64;
    localparam int MaxOut   = 4;
    localparam int CntW     = $clog2(MaxOut + 1);

    logic                         clk = 1'b0;
    logic                         rst_i;
    logic [NumReq-1:0]            req_valid_i;
    logic [NumReq-1:0]            req_ready_o;
    logic [NumReq*ReqWidth-1:0]   req_i;
    logic [NumReq-1:0]            rsp_valid_o;
    logic [NumReq-1:0]            rsp_ready_i;
    logic [RspWidth-1:0]          rsp_o;
    logic [ReqWidth-1:0]          be_req_o;
    logic                         be_req_valid_o;
    logic                         be_req_ready_i;
    logic [RspWidth-1:0]          be_rsp_i;
    logic                         be_rsp_valid_i;
    logic                         be_rsp_ready_o;
    logic [CntW-1:0]              outstanding_o;
    logic                         idle_o;

    always #5 clk = ~clk;

    idma_backend_req_arbiter #(
        .NumReq        (NumReq),
        .ReqWidth      (ReqWidth),
        .RspWidth      (RspWidth),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_i         (req_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_o         (rsp_o),
        .be_req_o      (be_req_o),
        .be_req_valid_o(be_req_valid_o),
        .be_req_ready_i(be_req_ready_i),
        .be_rsp_i      (be_rsp_i),
        .be_rsp_valid_i(be_rsp_valid_i),
        .be_rsp_ready_o(be_rsp_ready_o),
        .outstanding_o (outstanding_o),
        .idle_o        (idle_o)
    );

    int compared   = 0;
    int mismatched = 0;
    int proto_err  = 0;

    // Requester / backend stimulus state.
    bit                pend [NumReq];
    logic [ReqWidth-1:0] pdata [NumReq];
    bit                bready;
    bit                rpend;
    bit                rst;
    logic [RspWidth-1:0] rdata;
    logic [NumReq-1:0] rrdy;

    // Reference model: queue of granted requester indices in acceptance order.
    int q[$];
    int rr;
    bit lock;
    int lidx;

    // Observations captured at the check point of the last cycle.
    logic                s_be_valid;
    logic [ReqWidth-1:0] s_be_req;
    logic [NumReq-1:0]   s_req_ready;
    logic [NumReq-1:0]   s_rsp_valid;
    logic                s_be_rsp_ready;
    logic [RspWidth-1:0] s_rsp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int w;
        bit found, full, e_bv, e_brr, rq_hs, rs_hs;
        logic [NumReq-1:0] e_rv, e_rr;
        rst_i          = rst;
        for (int k = 0; k < NumReq; k++) begin
            req_valid_i[k]                  = pend[k];
            req_i[k*ReqWidth +: ReqWidth]   = pdata[k];
        end
        be_req_ready_i = bready;
        be_rsp_valid_i = rpend;
        be_rsp_i       = rdata;
        rsp_ready_i    = rrdy;
        @(negedge clk);
        #1;
        full  = (q.size() == MaxOut);
        w     = 0;
        found = 0;
        if (lock) begin
            w = lidx;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (!found && req_valid_i[(rr + i) % NumReq]) begin
                    w     = (rr + i) % NumReq;
                    found = 1;
                end
            end
        end
        e_bv = (req_valid_i != 0) && !full;
        e_rr = (e_bv && be_req_ready_i) ? (4'b0001 << w) : 4'b0000;
        if (q.size() > 0) begin
            e_rv  = be_rsp_valid_i ? (4'b0001 << q[0]) : 4'b0000;
            e_brr = rsp_ready_i[q[0]];
        end else begin
            e_rv  = '0;
            e_brr = 0;
            if (be_rsp_valid_i) proto_err++;
        end
        check("be_req_valid", be_req_valid_o, e_bv);
        check("req_ready", req_ready_o, e_rr);
        if (e_bv) check("be_req", be_req_o, pdata[w]);
        check("rsp_valid", rsp_valid_o, e_rv);
        check("be_rsp_ready", be_rsp_ready_o, e_brr);
        if (e_rv != 0) check("rsp_data", rsp_o, rdata);
        check("outstanding", outstanding_o, q.size());
        check("idle", idle_o, (q.size() == 0) && (req_valid_i == 0));
        s_be_valid     = be_req_valid_o;
        s_be_req       = be_req_o;
        s_req_ready    = req_ready_o;
        s_rsp_valid    = rsp_valid_o;
        s_be_rsp_ready = be_rsp_ready_o;
        s_rsp          = rsp_o;
        rq_hs = e_bv && be_req_ready_i;
        rs_hs = be_rsp_valid_i && e_brr;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            rr   = 0;
            lock = 0;
        end else begin
            if (rs_hs) begin
                void'(q.pop_front());
                rpend = 0;
            end
            if (rq_hs) begin
                q.push_back(w);
                rr      = (w + 1) % NumReq;
                lock    = 0;
                pend[w] = 0;
            end else if (e_bv) begin
                lock = 1;
                lidx = w;
            end
        end
    endtask

    task automatic do_reset();
        rst    = 1;
        bready = 0;
        rpend  = 0;
        cycle();
        rst    = 0;
    endtask

    task automatic drain();
        bready = 0;
        rrdy   = '1;
        repeat (MaxOut + 2) begin
            rpend = (q.size() > 0);
            rdata = {$urandom, $urandom};
            cycle();
        end
        rpend = 0;
    endtask

    initial begin
        logic [RspWidth-1:0] r1, r2;
        logic [ReqWidth-1:0] p2;
        rr = 0; lock = 0; lidx = 0;
        rst = 0; bready = 0; rpend = 0; rrdy = '0; rdata = '0;
        for (int k = 0; k < NumReq; k++) begin
            pend[k]  = 0;
            pdata[k] = '0;
        end
        rst_i = 1; req_valid_i = '0; req_i = '0; be_req_ready_i = 0;
        be_rsp_valid_i = 0; be_rsp_i = '0; rsp_ready_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 0;

        // Reset state.
        cycle();
        check("rst_idle", idle_o, 1'b1);
        check("rst_outstanding", outstanding_o, 0);

        // Single requester.
        pend[2]  = 1;
        pdata[2] = {16{8'hA5}};
        bready   = 1;
        cycle();
        check("single_be_valid", s_be_valid, 1'b1);
        check("single_be_req", s_be_req, {16{8'hA5}});
        check("single_req_ready", s_req_ready, 4'b0100);
        check("single_outstanding", outstanding_o, 1);
        bready = 0; rpend = 1; rdata = 64'h11; rrdy = 4'b0100;
        cycle();
        check("single_rsp_valid", s_rsp_valid, 4'b0100);
        check("single_rsp", s_rsp, 64'h11);
        check("single_out_zero", outstanding_o, 0);
        check("single_idle", idle_o, 1'b1);

        // Round-robin fairness with the backend always ready.
        do_reset();
        bready = 1;
        rrdy   = '1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NumReq; k++) begin
                pend[k]  = 1;
                pdata[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            rpend = (q.size() > 0);
            rdata = {$urandom, $urandom};
            cycle();
            check("rr_grant", s_req_ready, 4'b0001 << (i % 4));
        end
        for (int k = 0; k < NumReq; k++) pend[k] = 0;
        drain();

        // Lock under backpressure.
        do_reset();
        p2       = {$urandom, $urandom, $urandom, $urandom};
        pend[2]  = 1;
        pdata[2] = p2;
        bready   = 0;
        cycle();
        check("lock_be_req0", s_be_req, p2);
        pend[0]  = 1;
        pdata[0] = ~p2;
        repeat (2) begin
            cycle();
            check("lock_be_req", s_be_req, p2);
            check("lock_no_ready", s_req_ready, 4'b0000);
        end
        bready = 1;
        cycle();
        check("lock_grant2", s_req_ready, 4'b0100);
        pend[3]  = 1;
        pdata[3] = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        check("lock_then3", s_req_ready, 4'b1000);
        cycle();
        check("lock_then0", s_req_ready, 4'b0001);
        drain();

        // Full FIFO blocks grants; reopens one cycle after a pop.
        do_reset();
        bready = 1;
        repeat (4) begin
            for (int k = 0; k < NumReq; k++) pend[k] = 1;
            cycle();
        end
        check("full_out4", outstanding_o, 4);
        for (int k = 0; k < NumReq; k++) pend[k] = 1;
        cycle();
        check("full_no_valid", s_be_valid, 1'b0);
        check("full_no_ready", s_req_ready, 4'b0000);
        rpend = 1; rdata = 64'hCAFE; rrdy = '1;
        cycle();
        check("full_pop_no_valid", s_be_valid, 1'b0);
        check("full_out3", outstanding_o, 3);
        rpend = 0;
        cycle();
        check("full_reopen", s_be_valid, 1'b1);
        check("full_out4b", outstanding_o, 4);
        for (int k = 0; k < NumReq; k++) pend[k] = 0;
        drain();

        // Response routing and backpressure.
        do_reset();
        bready  = 1;
        pend[1] = 1;
        cycle();
        pend[3] = 1;
        cycle();
        check("route_grant3", s_req_ready, 4'b1000);
        bready = 0;
        r1 = 64'h1111_2222_3333_4444;
        r2 = 64'h5555_6666_7777_8888;
        rpend = 1; rdata = r1; rrdy = 4'b1000;
        repeat (2) begin
            cycle();
            check("route_hold_valid", s_rsp_valid, 4'b0010);
            check("route_hold_ready", s_be_rsp_ready, 1'b0);
        end
        rrdy = 4'b1010;
        cycle();
        check("route_r1_valid", s_rsp_valid, 4'b0010);
        check("route_r1_data", s_rsp, r1);
        rpend = 1; rdata = r2;
        cycle();
        check("route_r2_valid", s_rsp_valid, 4'b1000);
        check("route_r2_data", s_rsp, r2);
        check("route_out0", outstanding_o, 0);

        // Reset mid-operation, then a stray backend response.
        bready = 1;
        for (int k = 0; k < 3; k++) begin
            pend[k] = 1;
            cycle();
        end
        check("mid_out3", outstanding_o, 3);
        do_reset();
        check("mid_rst_out0", outstanding_o, 0);
        bready = 0; rpend = 1; rdata = 64'hDEAD; rrdy = '1;
        cycle();
        check("stray_be_rsp_ready", s_be_rsp_ready, 1'b0);
        check("stray_rsp_valid", s_rsp_valid, 4'b0000);
        check("stray_detected", proto_err, 1);
        rpend = 0;
        for (int k = 0; k < NumReq; k++) pend[k] = 1;
        bready = 1;
        cycle();
        check("mid_rr_zero", s_req_ready, 4'b0001);
        for (int k = 0; k < NumReq; k++) pend[k] = 0;
        drain();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                for (int k = 0; k < NumReq; k++) begin
                    if (!pend[k] && $urandom_range(0, 2) == 0) begin
                        pend[k]  = 1;
                        pdata[k] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
                bready = ($urandom_range(0, 9) < 7);
                if (!rpend && q.size() > 0 && $urandom_range(0, 1) == 0) begin
                    rpend = 1;
                    rdata = {$urandom, $urandom};
                end
                rrdy = NumReq'($urandom);
                cycle();
            end
        end
        check("proto_err_total", proto_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
